// File: rtl/reg_dump_pkg.sv
// Shared types and constants for the register-dump reader.
// REG_DUMP_CSUM_EN adds the checksum state.
package reg_dump_pkg;

  localparam int unsigned REG_DUMP_NREGS = 32;

  typedef enum logic [1:0] {
    StIdle,
    StSend,
`ifdef REG_DUMP_CSUM_EN
    StCsum,
`endif
    StDone
  } reg_dump_state_t;

endpackage

// File: rtl/reg_snap_buf.sv
// 32-entry capture buffer for the register snapshot, with an indexed combinational read.
// Entry 0 is always captured as zero.
module reg_snap_buf
  import reg_dump_pkg::*;
#(
  parameter int unsigned DATA_W = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              capture,
  input  logic [DATA_W-1:0] wr_data [0:REG_DUMP_NREGS-1],
  input  logic [4:0]        rd_idx,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem_q [0:REG_DUMP_NREGS-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < REG_DUMP_NREGS; i++) mem_q[i] <= '0;
    end else if (capture) begin
      for (int i = 0; i < REG_DUMP_NREGS; i++) mem_q[i] <= (i == 0) ? '0 : wr_data[i];
    end
  end

  assign rd_data = mem_q[rd_idx];

endmodule

// File: rtl/reg_dump_reader.sv
// Captures the register file on the rising edge of finish and streams it out over valid/ready.
// Define REG_DUMP_CSUM_EN to append an XOR checksum beat after the registers.
`ifndef REG_WIDTH
`define REG_WIDTH 64
`endif

module reg_dump_reader
  import reg_dump_pkg::*;
#(
  parameter int unsigned DATA_W    = `REG_WIDTH,
  parameter bit          SKIP_ZERO = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              finish,
  input  logic [DATA_W-1:0] reg_snap [0:REG_DUMP_NREGS-1],
  output logic              out_valid,
  input  logic              out_ready,
  output logic [4:0]        out_idx,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              out_csum,
  output logic              busy,
  output logic              done
);

`ifdef REG_DUMP_CSUM_EN
  localparam bit CsumEn = 1'b1;
`else
  localparam bit CsumEn = 1'b0;
`endif

  reg_dump_state_t   state_q, state_d;
  logic [4:0]        idx_q, idx_d;
  logic              finish_q;
  logic              capture;
  logic [DATA_W-1:0] rd_data;
`ifdef REG_DUMP_CSUM_EN
  logic [DATA_W-1:0] acc_q, acc_d;
`endif

  reg_snap_buf #(
    .DATA_W(DATA_W)
  ) u_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .capture (capture),
    .wr_data (reg_snap),
    .rd_idx  (idx_q),
    .rd_data (rd_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      idx_q    <= '0;
      finish_q <= 1'b0;
`ifdef REG_DUMP_CSUM_EN
      acc_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      finish_q <= finish;
`ifdef REG_DUMP_CSUM_EN
      acc_q    <= acc_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    capture = 1'b0;
`ifdef REG_DUMP_CSUM_EN
    acc_d   = acc_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (finish && !finish_q) begin
          capture = 1'b1;
          idx_d   = SKIP_ZERO ? 5'd1 : 5'd0;
          state_d = StSend;
`ifdef REG_DUMP_CSUM_EN
          acc_d   = '0;
`endif
        end
      end
      StSend: begin
        if (out_ready) begin
`ifdef REG_DUMP_CSUM_EN
          acc_d = acc_q ^ rd_data;
`endif
          if (idx_q == 5'd31) begin
`ifdef REG_DUMP_CSUM_EN
            state_d = StCsum;
`else
            state_d = StDone;
`endif
          end else begin
            idx_d = idx_q + 5'd1;
          end
        end
      end
`ifdef REG_DUMP_CSUM_EN
      StCsum: begin
        if (out_ready) state_d = StDone;
      end
`endif
      StDone:  state_d = StDone;
      default: state_d = StIdle;
    endcase
  end

  // Outputs decode registered state only; nothing here depends on out_ready or finish.
  always_comb begin
    out_valid = 1'b0;
    out_idx   = '0;
    out_data  = '0;
    out_last  = 1'b0;
    out_csum  = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    unique case (state_q)
      StSend: begin
        out_valid = 1'b1;
        out_idx   = idx_q;
        out_data  = rd_data;
        out_last  = (idx_q == 5'd31) && !CsumEn;
        busy      = 1'b1;
      end
`ifdef REG_DUMP_CSUM_EN
      StCsum: begin
        out_valid = 1'b1;
        out_data  = acc_q;
        out_last  = 1'b1;
        out_csum  = 1'b1;
        busy      = 1'b1;
      end
`endif
      StDone:  done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_reg_dump_reader.sv
// Self-checking bench: two readers (SKIP_ZERO 0 and 1) against a beat-queue model.
// Follows REG_DUMP_CSUM_EN to decide whether a checksum beat is expected.
module tb_reg_dump_reader;

`ifdef REG_DUMP_CSUM_EN
  localparam bit Csum = 1'b1;
`else
  localparam bit Csum = 1'b0;
`endif

  typedef struct packed {
    logic [4:0]  idx;
    logic [63:0] data;
    logic        last;
    logic        csum;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        finish = 1'b0;
  logic        out_ready = 1'b0;
  logic [63:0] reg_snap [0:31];

  logic        v0, l0, c0, b0, dn0, v1, l1, c1, b1, dn1;
  logic [4:0]  i0, i1;
  logic [63:0] d0, d1;

  int          checks = 0;
  int          errors = 0;
  int          cnt0 = 0;
  int          cnt1 = 0;
  logic [63:0] csum_seen = '0;
  logic [63:0] data_idx5 = '0;
  bit          rand_ready = 1'b0;

  beat_t       q0[$];
  beat_t       q1[$];
  bit          md0 = 1'b0;
  bit          md1 = 1'b0;
  bit          pf = 1'b0;

  always #5 clk = ~clk;

  reg_dump_reader #(.DATA_W(64), .SKIP_ZERO(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .finish(finish), .reg_snap(reg_snap),
    .out_valid(v0), .out_ready(out_ready), .out_idx(i0), .out_data(d0),
    .out_last(l0), .out_csum(c0), .busy(b0), .done(dn0)
  );

  reg_dump_reader #(.DATA_W(64), .SKIP_ZERO(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .finish(finish), .reg_snap(reg_snap),
    .out_valid(v1), .out_ready(out_ready), .out_idx(i1), .out_data(d1),
    .out_last(l1), .out_csum(c1), .busy(b1), .done(dn1)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic beat_t reg_beat(input int i, input bit skip);
    beat_t b;
    b.idx  = 5'(i);
    b.data = (i == 0) ? 64'h0 : reg_snap[i];
    b.last = (i == 31) && !Csum;
    b.csum = 1'b0;
    return b;
  endfunction

  function automatic beat_t csum_beat(input bit skip);
    beat_t b;
    b = '0;
    for (int i = (skip ? 1 : 0); i < 32; i++) b.data ^= (i == 0) ? 64'h0 : reg_snap[i];
    b.last = 1'b1;
    b.csum = 1'b1;
    return b;
  endfunction

  // Model: the whole dump is the list of beats fixed at capture; each accept pops one.
  always @(posedge clk or negedge rst_n) begin : model
    bit dn0_now, dn1_now;
    if (!rst_n) begin
      q0.delete();
      q1.delete();
      md0 <= 1'b0;
      md1 <= 1'b0;
      pf  <= 1'b0;
    end else begin
      dn0_now = md0;
      dn1_now = md1;
      if (q0.size() > 0 && out_ready) begin
        if (q0[0].last) dn0_now = 1'b1;
        void'(q0.pop_front());
      end
      if (q1.size() > 0 && out_ready) begin
        if (q1[0].last) dn1_now = 1'b1;
        void'(q1.pop_front());
      end
      if (finish && !pf) begin
        if (q0.size() == 0 && !dn0_now) begin
          for (int i = 0; i < 32; i++) q0.push_back(reg_beat(i, 1'b0));
          if (Csum) q0.push_back(csum_beat(1'b0));
        end
        if (q1.size() == 0 && !dn1_now) begin
          for (int i = 1; i < 32; i++) q1.push_back(reg_beat(i, 1'b1));
          if (Csum) q1.push_back(csum_beat(1'b1));
        end
      end
      md0 <= dn0_now;
      md1 <= dn1_now;
      pf  <= finish;
    end
  end

  task automatic cmp(input string tag, input logic v, input logic [4:0] idx, input logic [63:0] data,
                     input logic last, input logic cs, input logic bsy, input logic dn,
                     input bit ev, input beat_t eb, input bit edn);
    check({tag, ".valid"}, 64'(v), 64'(ev));
    check({tag, ".busy"}, 64'(bsy), 64'(ev));
    check({tag, ".done"}, 64'(dn), 64'(edn));
    check({tag, ".idx"}, 64'(idx), ev ? 64'(eb.idx) : 64'h0);
    check({tag, ".data"}, data, ev ? eb.data : 64'h0);
    check({tag, ".last"}, 64'(last), ev ? 64'(eb.last) : 64'h0);
    check({tag, ".csum"}, 64'(cs), ev ? 64'(eb.csum) : 64'h0);
  endtask

  always @(negedge clk) begin : compare
    beat_t e0, e1;
    if (rst_n) begin
      e0 = '0;
      e1 = '0;
      if (q0.size() > 0) e0 = q0[0];
      if (q1.size() > 0) e1 = q1[0];
      cmp("d0", v0, i0, d0, l0, c0, b0, dn0, q0.size() > 0, e0, md0);
      cmp("d1", v1, i1, d1, l1, c1, b1, dn1, q1.size() > 0, e1, md1);
      if (v0 && out_ready) begin
        cnt0++;
        if (i0 == 5'd5) data_idx5 = d0;
      end
      if (v1 && out_ready) begin
        cnt1++;
        if (c1) csum_seen = d1;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
    if (rand_ready) out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic load_snap();
    for (int i = 0; i < 32; i++) reg_snap[i] = 64'h1000 + 64'(i);
    reg_snap[0] = 64'hDEAD;
  endtask

  task automatic do_reset(input logic fin);
    rst_n      = 1'b0;
    out_ready  = 1'b0;
    rand_ready = 1'b0;
    finish     = fin;
    cnt0 = 0;
    cnt1 = 0;
    repeat (2) step();
    rst_n = 1'b1;
  endtask

  task automatic wait_done();
    int n = 0;
    while (!(dn0 && dn1) && n < 400) begin
      step();
      n++;
    end
    check("dump_completes_in_budget", 64'(n < 400), 64'h1);
  endtask

  initial begin
    load_snap();
    do_reset(1'b0);
    #1;
    check("reset.valid", 64'(v0), 64'h0);
    check("reset.data", d0, 64'h0);
    check("reset.busy", 64'(b0), 64'h0);
    check("reset.done", 64'(dn1), 64'h0);

    // Full dump, ready always high
    out_ready = 1'b1;
    step();
    finish = 1'b1;
    step();
    check("first_beat.valid", 64'(v0), 64'h1);
    check("first_beat.idx0_zeroed", d0, 64'h0);
    check("first_beat.skip_idx", 64'(i1), 64'h1);
    check("first_beat.skip_data", d1, 64'h1001);
    finish = 1'b0;
    wait_done();
    check("full.beats_d0", 64'(cnt0), 64'(32 + int'(Csum)));
    check("full.beats_d1", 64'(cnt1), 64'(31 + int'(Csum)));
`ifdef REG_DUMP_CSUM_EN
    check("full.csum_value", csum_seen, 64'h1000);
`endif

    // finish held high across reset release, random ready, snapshot overwritten after capture
    do_reset(1'b1);
    rand_ready = 1'b1;
    step();
    for (int i = 0; i < 32; i++) reg_snap[i] = '1;
    wait_done();
    check("stall.beats_d0", 64'(cnt0), 64'(32 + int'(Csum)));
    check("stall.idx5_data", data_idx5, 64'h1005);
    finish = 1'b0;
    step();
    finish = 1'b1;
    repeat (6) step();
    check("refinish.no_extra_beats", 64'(cnt0), 64'(32 + int'(Csum)));

    // Reset in the middle of the stream
    load_snap();
    do_reset(1'b0);
    out_ready = 1'b1;
    step();
    finish = 1'b1;
    step();
    finish = 1'b0;
    begin
      int n = 0;
      while (!(v0 && i0 == 5'd10) && n < 50) begin
        step();
        n++;
      end
      check("reached_beat10", 64'(n < 50), 64'h1);
    end
    rst_n = 1'b0;
    #1;
    check("midreset.valid", 64'(v0), 64'h0);
    check("midreset.idx", 64'(i0), 64'h0);
    check("midreset.data", d1, 64'h0);
    check("midreset.busy", 64'(b1), 64'h0);
    step();
    rst_n = 1'b1;
    cnt0 = 0;
    cnt1 = 0;
    step();
    finish = 1'b1;
    step();
    check("restart.valid", 64'(v0), 64'h1);
    check("restart.idx", 64'(i0), 64'h0);
    finish = 1'b0;
    wait_done();
    check("restart.beats_d0", 64'(cnt0), 64'(32 + int'(Csum)));
    check("restart.beats_d1", 64'(cnt1), 64'(31 + int'(Csum)));
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/reg_dump_reader.md
# reg_dump_reader

Read-out end of the integer register file. When the core signals `finish`, this block captures a snapshot of all 32 architectural registers and streams them out one per beat over a valid/ready handshake, so the simulation harness can compare final machine state. It sits beside the register file: it consumes the register file's full-array output and `finish`, and drives the harness-facing stream.

## Interface
Parameters:
- `DATA_W`, default `` `REG_WIDTH `` (64): register and stream data width.
- `SKIP_ZERO`, default 0: 1 = start the stream at x1; 0 = emit x0 (always as 0).

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `finish` in 1: program-end flag; a level that may stay high.
- `reg_snap` in [DATA_W-1:0] x [0:31]: current register array from the register file.
- `out_valid` out 1: beat present.
- `out_ready` in 1: harness accepts the beat.
- `out_idx` out 5: register index of the beat.
- `out_data` out DATA_W: register value.
- `out_last` out 1: final beat of the dump.
- `out_csum` out 1: beat carries the checksum (0 when `REG_DUMP_CSUM_EN` is undefined).
- `busy` out 1: snapshot held, stream in progress.
- `done` out 1: dump complete; sticky until reset.

## Operation
- FSM states: IDLE, SEND, CSUM (only with `REG_DUMP_CSUM_EN`), DONE.
- IDLE: a rising edge of `finish` (`finish & ~finish_q`) copies `reg_snap` into the internal snapshot. The snapshot entry for x0 is forced to 0. The index loads to `SKIP_ZERO ? 1 : 0` and the FSM goes to SEND.
- SEND: `out_valid`=1, `out_idx`=index, `out_data`=snap[index], `out_last`=(index==31 and no CSUM).
  - A beat transfers on `out_valid & out_ready`.
  - Index 31 transferred: go to CSUM if enabled, otherwise DONE.
  - Any other transfer: increment the index.
- CSUM: one beat with `out_data` = XOR of all 32 snapshot entries (x0 contributes 0), `out_idx`=0, `out_csum`=1, `out_last`=1. On transfer, go to DONE.
- DONE: outputs idle, `done`=1. Further `finish` edges are ignored until reset.
- Changes to `reg_snap` after capture never affect the stream.
- `finish` already high when reset deasserts: `finish_q` resets to 0, so this counts as a rising edge on the first clock.

## Timing
- Reset values: `out_valid`=0, `out_idx`=0, `out_data`=0, `out_last`=0, `out_csum`=0, `busy`=0, `done`=0. The FSM is in IDLE, the index is 0 and `finish_q` is 0.
- Reset mid-stream: all outputs clear asynchronously and the snapshot is discarded.
- All outputs are registered or decoded from registered state only; there is no combinational path from `out_ready` or `finish` to any output.
- Latency: `finish` rises in cycle N, so the first beat is valid in cycle N+1.
- Throughput: one beat per cycle while `out_ready`=1.
  - Full dump: 32 beats (31 with `SKIP_ZERO`), plus 1 for CSUM.
  - `done` rises in the cycle after the last transfer.
- Handshake: while `out_valid` is high, `out_idx`, `out_data`, `out_last` and `out_csum` hold stable until transfer. `out_valid` never drops without a transfer, except on reset.
- Index arithmetic is 5-bit. The increment at 31 never occurs, so there is no wrap.

## Configuration
- `REG_DUMP_CSUM_EN` defined:
  - The CSUM state and the XOR accumulator are compiled in.
  - The accumulator is computed incrementally as beats transfer, not as a 32-way XOR tree.
  - Register beat 31 has `out_last`=0; the checksum beat is last.
- `REG_DUMP_CSUM_EN` undefined: there is no CSUM state or accumulator, `out_csum` is tied to 0, and register beat 31 is last.

## Structure
- `` `REG_WIDTH `` comes from the existing shared defines include.
- The FSM state enum `reg_dump_state_t` and the constant `REG_DUMP_NREGS` (32) go in a new shared package, `reg_dump_pkg`.
- One sub-module, `reg_snap_buf`: a 32xDATA_W capture buffer with a capture strobe and an indexed combinational read. The FSM, handshake and checksum stay in the top level.

## Test plan
- Preload xN = 0x1000+N, with snap[0]=0xDEAD. Pulse `finish` with `out_ready`=1.
  - Required: beats idx 0..31 in consecutive cycles starting at N+1.
  - idx0 data = 0 (not 0xDEAD); `out_last` only on idx31; `done`=1 afterwards.
- Toggle `out_ready` pseudo-randomly.
  - Required: no beat lost or duplicated, and held data stable while stalled.
- Change `reg_snap` to all-ones after capture.
  - Required: the stream still emits the 0x1000+N values.
- Assert `rst_n`=0 at beat 10, then release, then pulse `finish`.
  - Required: outputs clear immediately, and the dump restarts at idx 0.
- Hold `finish` high throughout; also pulse it again after `done`.
  - Required: exactly one dump.
- With `REG_DUMP_CSUM_EN` and `SKIP_ZERO`=1, values 0x1000+N.
  - Required: 31 beats (idx 1..31), then a checksum beat with data = XOR over N=1..31 of (0x1000+N).
  - The checksum beat has `out_csum`=1 and `out_last`=1.
